// File: rtl/bus_master_if_pkg.sv
// Shared types and constants for the per-master bus interface.
// Bus control levels are active-low, so the enable/disable names are used instead of 0/1.
package bus_master_if_pkg;

    localparam int DEFAULT_ADDR_W = 30;
    localparam int DEFAULT_DATA_W = 32;
    localparam int BUS_IF_STATE_W = 2;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [BUS_IF_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_STALL  = 2'd3
    } bus_if_state_t;

endpackage

// File: rtl/bus_master_if_watchdog.sv
// Access watchdog: counts cycles spent waiting for the slave.
// The expired flag is raised combinationally when the count reaches TIMEOUT-1.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= 8'd0;
        end else if (enable) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign expired = (cnt_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_master_if.sv
// Per-master bus interface: converts one CPU access into a request/grant,
// a single-cycle address strobe, and a wait for slave ready (with timeout).
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_busy,
    output logic              cpu_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    bus_if_state_t     state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              rw_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [DATA_W-1:0] rd_buf_reg;

    logic rdy;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign rdy       = (bus_rdy_ == ENABLE_);
    assign wd_clear  = (state_reg != ST_ACCESS);
    assign wd_enable = (state_reg == ST_ACCESS) && !rdy && !wd_expired;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Completion is reported in the same cycle the slave signals ready.
    always_comb begin
        cpu_busy    = 1'b0;
        cpu_rd_data = rd_buf_reg;
        case (state_reg)
            ST_IDLE:   cpu_busy = cpu_req;
            ST_REQ:    cpu_busy = 1'b1;
            ST_ACCESS: begin
                cpu_busy = !rdy && !wd_expired;
                if (rdy) begin
                    cpu_rd_data = bus_rd_data;
                end
            end
            default:   cpu_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            rw_reg      <= BUS_READ;
            wr_data_reg <= '0;
            rd_buf_reg  <= '0;
            cpu_err     <= 1'b0;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_rw      <= BUS_READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            cpu_err <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_req && !flush) begin
                        addr_reg    <= cpu_addr;
                        rw_reg      <= cpu_rw;
                        wr_data_reg <= cpu_wr_data;
                        bus_req_    <= ENABLE_;
                        state_reg   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        bus_req_  <= DISABLE_;
                        state_reg <= ST_IDLE;
                    end else if (bus_grnt_ == ENABLE_) begin
                        bus_as_     <= ENABLE_;
                        bus_addr    <= addr_reg;
                        bus_rw      <= rw_reg;
                        bus_wr_data <= wr_data_reg;
                        state_reg   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    bus_as_ <= DISABLE_;
                    // Bus request stays asserted until the cycle ends so ownership is kept.
                    if (rdy || wd_expired) begin
                        bus_req_    <= DISABLE_;
                        bus_rw      <= BUS_READ;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                        if (rdy) begin
                            if (rw_reg == BUS_READ) begin
                                rd_buf_reg <= bus_rd_data;
                            end
                            state_reg <= stall ? ST_STALL : ST_IDLE;
                        end else begin
                            cpu_err   <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: the bench acts as CPU, arbiter and slave,
// and derives expected timing and data from request/grant/ready delays.
module tb_bus_master_if;
    import bus_master_if_pkg::*;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_busy;
    logic              cpu_err;
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] last_read;

    always #5 clk = ~clk;

    bus_master_if #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .stall       (stall),
        .flush       (flush),
        .cpu_rd_data (cpu_rd_data),
        .cpu_busy    (cpu_busy),
        .cpu_err     (cpu_err),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    // One CPU access. The arbiter grants gdly cycles after it first sees bus_req_ low;
    // the slave answers rdly cycles after the strobe (rdly >= TIMEOUT means never).
    task automatic test_access(input string tag, input logic rw, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                               input int gdly, input int rdly, input int stall_n);
        int k, as_cycle, req_low, grant_cycle, busy_low, err_cycle, as_cnt, done_cycle;
        logic expect_to;
        logic [DATA_W-1:0] got_data, as_wdata, exp_buf;
        logic [ADDR_W-1:0] as_addr;
        logic as_rw;
        k = 0; as_cycle = -1; req_low = 0; grant_cycle = -1; busy_low = -1;
        err_cycle = -1; as_cnt = 0; done_cycle = -1;
        got_data = '0; as_wdata = '0; as_addr = '0; as_rw = 1'b0;
        expect_to = (rdly >= TIMEOUT);
        exp_buf = (rw == BUS_READ && !expect_to) ? rdata : last_read;

        @(posedge clk); #1;
        n_tests++;
        if (bus_req_ !== DISABLE_) begin
            n_fail++; $display("FAIL %s req_gap: bus_req_=%b expected 1", tag, bus_req_);
        end
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wdata;
        flush = 1'b0; stall = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        #1;
        n_tests++;
        if (cpu_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s idle_busy: cpu_busy=%b expected 1", tag, cpu_busy);
        end

        while (k < 60 && done_cycle < 0 && err_cycle < 0) begin
            @(posedge clk); #1; k++;
            if (cpu_err === 1'b1) err_cycle = k;
            if (bus_req_ === 1'b0) begin
                req_low++;
                if (grant_cycle < 0 && req_low > gdly) grant_cycle = k;
            end
            bus_grnt_ = (bus_req_ === 1'b0 && grant_cycle >= 0) ? 1'b0 : 1'b1;
            if (bus_as_ === 1'b0) begin
                as_cnt++;
                if (as_cycle < 0) begin
                    as_cycle = k; as_addr = bus_addr; as_rw = bus_rw; as_wdata = bus_wr_data;
                end
            end else if (as_cycle >= 0 && err_cycle < 0) begin
                n_tests++;
                if (bus_addr !== as_addr || bus_rw !== as_rw || bus_wr_data !== as_wdata) begin
                    n_fail++;
                    $display("FAIL %s hold@%0d: addr=%h rw=%b wd=%h expected addr=%h rw=%b wd=%h",
                             tag, k, bus_addr, bus_rw, bus_wr_data, as_addr, as_rw, as_wdata);
                end
            end
            if (as_cycle >= 0 && !expect_to && k - as_cycle == rdly) begin
                bus_rdy_ = 1'b0; bus_rd_data = rdata; stall = (stall_n > 0);
            end else begin
                bus_rdy_ = 1'b1; bus_rd_data = $urandom;
            end
            #1;
            if (as_cycle < 0 && err_cycle < 0) begin
                n_tests++;
                if (cpu_busy !== 1'b1) begin
                    n_fail++; $display("FAIL %s req_busy@%0d: cpu_busy=%b expected 1", tag, k, cpu_busy);
                end
            end else if (busy_low < 0 && cpu_busy === 1'b0) begin
                busy_low = k; got_data = cpu_rd_data; cpu_req = 1'b0;
            end else if (busy_low < 0) begin
                n_tests++;
                if (cpu_rd_data !== last_read) begin
                    n_fail++; $display("FAIL %s wait_rd@%0d: cpu_rd_data=%h expected %h", tag, k, cpu_rd_data, last_read);
                end
            end
            if (bus_rdy_ === 1'b0) done_cycle = k;
        end
        cpu_req = 1'b0;

        n_tests++;
        if (done_cycle < 0 && !(expect_to && err_cycle >= 0)) begin
            n_fail++; $display("FAIL %s end: done@%0d err@%0d expected completion=%b", tag, done_cycle, err_cycle, !expect_to);
        end
        n_tests++;
        if (as_cnt != 1) begin
            n_fail++; $display("FAIL %s as_count: %0d expected 1", tag, as_cnt);
        end
        n_tests++;
        if (as_cycle != gdly + 2) begin
            n_fail++; $display("FAIL %s as_cycle: %0d expected %0d", tag, as_cycle, gdly + 2);
        end
        n_tests++;
        if (as_addr !== addr || as_rw !== rw) begin
            n_fail++; $display("FAIL %s as_addr_rw: addr=%h rw=%b expected addr=%h rw=%b", tag, as_addr, as_rw, addr, rw);
        end
        if (rw == BUS_WRITE) begin
            n_tests++;
            if (as_wdata !== wdata) begin
                n_fail++; $display("FAIL %s as_wdata: %h expected %h", tag, as_wdata, wdata);
            end
        end

        if (expect_to) begin
            n_tests++;
            if (busy_low != as_cycle + TIMEOUT - 1 || err_cycle != as_cycle + TIMEOUT) begin
                n_fail++;
                $display("FAIL %s timeout: busy_low@%0d err@%0d expected busy_low@%0d err@%0d",
                         tag, busy_low, err_cycle, as_cycle + TIMEOUT - 1, as_cycle + TIMEOUT);
            end
        end else begin
            n_tests++;
            if (busy_low != as_cycle + rdly) begin
                n_fail++; $display("FAIL %s busy_low: @%0d expected @%0d", tag, busy_low, as_cycle + rdly);
            end
            if (rw == BUS_READ) begin
                n_tests++;
                if (got_data !== rdata) begin
                    n_fail++; $display("FAIL %s rd_data: %h expected %h", tag, got_data, rdata);
                end
            end
            for (int s = 1; s <= stall_n; s++) begin
                @(posedge clk); #1;
                bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
                if (s == stall_n) stall = 1'b0;
                #1;
                n_tests++;
                if (cpu_busy !== 1'b0 || cpu_rd_data !== exp_buf || bus_req_ !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s stall%0d: busy=%b rd=%h req_=%b expected busy=0 rd=%h req_=1",
                             tag, s, cpu_busy, cpu_rd_data, bus_req_, exp_buf);
                end
            end
        end

        @(posedge clk); #1;
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; stall = 1'b0;
        #1;
        n_tests++;
        if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || cpu_err !== 1'b0 || cpu_busy !== 1'b0 ||
            bus_addr !== '0 || cpu_rd_data !== exp_buf) begin
            n_fail++;
            $display("FAIL %s after: req_=%b as_=%b err=%b busy=%b addr=%h rd=%h expected 1 1 0 0 0 %h",
                     tag, bus_req_, bus_as_, cpu_err, cpu_busy, bus_addr, cpu_rd_data, exp_buf);
        end
        if (rw == BUS_READ && !expect_to) last_read = rdata;
        $display("[TB] txn %s rw=%0d addr=%h gdly=%0d rdly=%0d stall=%0d as@%0d busy_low@%0d err@%0d",
                 tag, rw, addr, gdly, rdly, stall_n, as_cycle, busy_low, err_cycle);
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b0; cpu_rw = BUS_WRITE; cpu_addr = '1; cpu_wr_data = '1;
        stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || bus_rw !== BUS_READ || bus_addr !== '0 ||
            bus_wr_data !== '0 || cpu_err !== 1'b0 || cpu_busy !== 1'b0 || cpu_rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: req_=%b as_=%b rw=%b addr=%h wd=%h err=%b busy=%b rd=%h",
                     bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, cpu_err, cpu_busy, cpu_rd_data);
        end
        reset = 1'b0;
        last_read = '0;
        $display("[TB] txn reset");
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        cpu_req = 1'b1; flush = 1'b1; cpu_rw = BUS_WRITE; cpu_addr = 30'h55; bus_grnt_ = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus_req_ !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle: bus_req_=%b expected 1", bus_req_);
        end
        flush = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus_req_ !== 1'b0 || cpu_busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_req: req_=%b busy=%b expected 0 1", bus_req_, cpu_busy);
        end
        @(posedge clk); #1;
        flush = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        n_tests++;
        if (bus_req_ !== 1'b1 || cpu_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_release: req_=%b busy=%b expected 1 0", bus_req_, cpu_busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus_as_ !== 1'b1 || bus_req_ !== 1'b1) begin
                n_fail++; $display("FAIL flush_quiet%0d: as_=%b req_=%b expected 1 1", i, bus_as_, bus_req_);
            end
        end
        $display("[TB] txn flush");
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_rw = BUS_READ; cpu_addr = 30'h3; bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
        while (k < 20 && bus_as_ !== 1'b0) begin
            @(posedge clk); #1; k++;
        end
        n_tests++;
        if (bus_as_ !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_as: bus_as_=%b expected 0 within 20 cycles", bus_as_);
        end
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; bus_grnt_ = 1'b1;
        #1;
        n_tests++;
        if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || bus_addr !== '0 || bus_rw !== BUS_READ ||
            cpu_busy !== 1'b0 || cpu_rd_data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: req_=%b as_=%b addr=%h rw=%b busy=%b rd=%h expected 1 1 0 1 0 0",
                     bus_req_, bus_as_, bus_addr, bus_rw, cpu_busy, cpu_rd_data);
        end
        last_read = '0;
        $display("[TB] txn reset_mid_access");
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 24; i++) begin
            a = ADDR_W'($urandom);
            test_access("rand", 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                        $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_access("read",      BUS_READ,  30'h100, 32'h0,        32'hDEADBEEF, 0, 2,  0);
        test_access("write",     BUS_WRITE, 30'h2A,  32'h12345678, 32'h0BADF00D, 5, 1,  0);
        test_flush();
        test_access("timeout",   BUS_READ,  30'h77,  32'h0,        32'h11111111, 1, 99, 0);
        test_access("after_to",  BUS_READ,  30'h78,  32'h0,        32'h22222222, 0, 0,  0);
        test_access("stall",     BUS_READ,  30'h3C,  32'h0,        32'hA5A5A5A5, 0, 1,  3);
        test_access("wr_stall",  BUS_WRITE, 30'h3D,  32'hCAFEF00D, 32'h33333333, 2, 3,  2);
        test_reset_mid();
        test_access("post_rst",  BUS_READ,  30'h10,  32'h0,        32'h44444444, 0, 0,  0);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
